// File: rtl/exception_sequencer.sv
// Exception sequencer for the multi-cycle MIPS datapath: saves the EPC, steers the
// memory-address mux to the cause's vector byte, waits out the read latency and loads the PC.
module exception_sequencer #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_exc,
  output logic        iord_override,
  output logic        epc_write,
  output logic [31:0] epc_out,
  output logic        pc_write,
  output logic [31:0] pc_out,
  output logic [1:0]  cause,
  output logic        exc_busy,
  output logic        exc_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT,
    S_LOAD
  } state_e;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  // Only the low byte of the read data is a vector; the upper bits are deliberately dropped.
  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data_in[31:8];

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_opcode || exc_overflow || exc_divzero) begin
          if (exc_opcode)        cause_d = 2'b01;
          else if (exc_overflow) cause_d = 2'b10;
          else                   cause_d = 2'b11;
          epc_d   = pc_in - 32'd4;
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_WAIT) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Moore strobes decoded from state; pc_out alone passes mem_data_in through combinationally.
  always_comb begin
    iord_exc      = 3'b000;
    iord_override = 1'b0;
    epc_write     = 1'b0;
    pc_write      = 1'b0;
    exc_done      = 1'b0;
    pc_out        = '0;
    exc_busy      = (state_q != S_IDLE);
    if (state_q != S_IDLE) begin
      iord_exc      = {1'b0, cause_q};
      iord_override = 1'b1;
    end
    if (state_q == S_CAPTURE) epc_write = 1'b1;
    if (state_q == S_LOAD) begin
      pc_write = 1'b1;
      exc_done = 1'b1;
      pc_out   = {24'b0, mem_data_in[7:0]};
    end
  end

  assign epc_out = epc_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: table-driven exceptions on a MEM_LATENCY=1 instance with a
// PC-load scoreboard, plus hand sequences for reset, busy-time requests and MEM_LATENCY=3.
module tb_exception_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        exc_opcode, exc_overflow, exc_divzero;
  logic [31:0] pc_in, mem_data_in;
  logic [2:0]  a_iord_exc;
  logic        a_iord_override, a_epc_write, a_pc_write, a_exc_busy, a_exc_done;
  logic [31:0] a_epc_out, a_pc_out;
  logic [1:0]  a_cause;

  logic        b_exc_opcode;
  logic [31:0] b_pc_in, b_mem;
  logic [2:0]  b_iord_exc;
  logic        b_iord_override, b_epc_write, b_pc_write, b_exc_busy, b_exc_done;
  logic [31:0] b_epc_out, b_pc_out;
  logic [1:0]  b_cause;

  exception_sequencer #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .iord_exc(a_iord_exc), .iord_override(a_iord_override), .epc_write(a_epc_write),
    .epc_out(a_epc_out), .pc_write(a_pc_write), .pc_out(a_pc_out), .cause(a_cause),
    .exc_busy(a_exc_busy), .exc_done(a_exc_done)
  );

  exception_sequencer #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .exc_opcode(b_exc_opcode), .exc_overflow(1'b0), .exc_divzero(1'b0),
    .pc_in(b_pc_in), .mem_data_in(b_mem),
    .iord_exc(b_iord_exc), .iord_override(b_iord_override), .epc_write(b_epc_write),
    .epc_out(b_epc_out), .pc_write(b_pc_write), .pc_out(b_pc_out), .cause(b_cause),
    .exc_busy(b_exc_busy), .exc_done(b_exc_done)
  );

  typedef struct {
    logic [2:0]  req;       // {opcode, overflow, divzero}
    logic [31:0] pc;
    logic [31:0] mem;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] pc_new;
    logic        busy_req;  // pulse divzero during WAIT and LOAD
  } vec_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_iord_exc"}, a_iord_exc, 3'b000);
    check({tag, "_override"}, a_iord_override, 1'b0);
    check({tag, "_epc_write"}, a_epc_write, 1'b0);
    check({tag, "_epc_out"}, a_epc_out, 32'h0);
    check({tag, "_pc_write"}, a_pc_write, 1'b0);
    check({tag, "_pc_out"}, a_pc_out, 32'h0);
    check({tag, "_cause"}, a_cause, 2'b00);
    check({tag, "_busy"}, a_exc_busy, 1'b0);
    check({tag, "_done"}, a_exc_done, 1'b0);
  endtask

  // Scoreboard side: every PC load must match the oldest expected exception.
  int   a_busy_len = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      a_busy_len = 0;
    end else begin
      if (a_exc_busy) begin
        a_busy_len++;
      end else if (a_busy_len != 0) begin
        check("busy_len", a_busy_len, 32'd3);
        a_busy_len = 0;
      end
      if (a_pc_write || a_exc_done) check("done_eq_pc_write", a_exc_done, a_pc_write);
      if (a_pc_write) begin
        check("pc_write_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sb_pc_out", a_pc_out, e.pc);
          check("sb_cause", a_cause, e.cause);
          check("sb_epc_out", a_epc_out, e.epc);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(posedge clk); #1;
    while (a_exc_busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_timeout", a_exc_busy, 1'b0);
  endtask

  // Drives one exception on dut_a and checks its fixed MEM_LATENCY=1 cycle pattern.
  task automatic run_exc(input vec_t v);
    wait_idle();
    {exc_opcode, exc_overflow, exc_divzero} = v.req;
    pc_in       = v.pc;
    mem_data_in = v.mem;
    sb_q.push_back(exp_t'{v.cause, v.epc, v.pc_new});
    @(posedge clk); #1;
    {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
    check("cap_epc_write", a_epc_write, 1'b1);
    check("cap_epc_out", a_epc_out, v.epc);
    check("cap_iord_exc", a_iord_exc, {1'b0, v.cause});
    check("cap_override", a_iord_override, 1'b1);
    check("cap_pc_write", a_pc_write, 1'b0);
    @(posedge clk); #1;
    if (v.busy_req) exc_divzero = 1'b1;
    check("wait_iord_exc", a_iord_exc, {1'b0, v.cause});
    check("wait_epc_write", a_epc_write, 1'b0);
    check("wait_pc_write", a_pc_write, 1'b0);
    @(posedge clk); #1;
    check("load_iord_exc", a_iord_exc, {1'b0, v.cause});
    check("load_override", a_iord_override, 1'b1);
    check("load_pc_write", a_pc_write, 1'b1);
    @(posedge clk); #1;
    exc_divzero = 1'b0;
    check("idle_busy", a_exc_busy, 1'b0);
    check("idle_iord_exc", a_iord_exc, 3'b000);
    check("idle_override", a_iord_override, 1'b0);
    check("idle_pc_out", a_pc_out, 32'h0);
    check("idle_cause_hold", a_cause, v.cause);
    check("idle_epc_hold", a_epc_out, v.epc);
    @(posedge clk); #1;
    check("idle2_busy", a_exc_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t post_rst;
    logic [31:0] b_mem_tbl[7];

    vecs[0] = '{3'b100, 32'h0000_0104, 32'hFFFF_FF40, 2'b01, 32'h0000_0100, 32'h40, 1'b0};
    vecs[1] = '{3'b011, 32'h0000_2000, 32'h1234_5678, 2'b10, 32'h0000_1FFC, 32'h78, 1'b0};
    vecs[2] = '{3'b001, 32'h0000_0000, 32'hAAAA_AA00, 2'b11, 32'hFFFF_FFFC, 32'h00, 1'b0};
    vecs[3] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_00FF, 2'b01, 32'hFFFF_FFFB, 32'hFF, 1'b0};
    vecs[4] = '{3'b010, 32'h8000_0004, 32'h5555_5581, 2'b10, 32'h8000_0000, 32'h81, 1'b1};
    post_rst = '{3'b010, 32'h0000_0A08, 32'h0000_0033, 2'b10, 32'h0000_0A04, 32'h33, 1'b0};
    b_mem_tbl = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hABCD_EF7C, 32'h99, 32'h99};

    reset = 1'b0;
    {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
    pc_in = '0; mem_data_in = '0;
    b_exc_opcode = 1'b0; b_pc_in = '0; b_mem = '0;
    repeat (2) @(negedge clk);
    check_a_reset("rst");
    check("rst_b_busy", b_exc_busy, 1'b0);
    check("rst_b_epc_out", b_epc_out, 32'h0);
    reset = 1'b1;

    foreach (vecs[i]) run_exc(vecs[i]);

    // Asynchronous reset in the middle of WAIT: outputs clear with no clock edge.
    wait_idle();
    exc_opcode = 1'b1; pc_in = 32'h0000_0300; mem_data_in = 32'h55;
    @(posedge clk); #1;
    exc_opcode = 1'b0;
    @(posedge clk); #1;
    check("prerst_busy", a_exc_busy, 1'b1);
    #1 reset = 1'b0;
    #1 check_a_reset("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_busy", a_exc_busy, 1'b0);
    check("rel_pc_write", a_pc_write, 1'b0);

    // Reset during CAPTURE: no PC load may follow; then a fresh overflow completes.
    exc_overflow = 1'b1; pc_in = 32'h0000_0500;
    @(posedge clk); #1;
    exc_overflow = 1'b0;
    check("cap2_epc_write", a_epc_write, 1'b1);
    #1 reset = 1'b0;
    #1 check("cap_rst_epc_write", a_epc_write, 1'b0);
    check("cap_rst_epc_out", a_epc_out, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("cap_rst_no_pc_write", a_pc_write, 1'b0);
      check("cap_rst_no_busy", a_exc_busy, 1'b0);
    end
    run_exc(post_rst);

    // MEM_LATENCY=3: override for 5 cycles, PC load in the 5th using the LOAD-cycle byte.
    b_exc_opcode = 1'b1; b_pc_in = 32'h0000_1008;
    @(posedge clk); #1;
    b_exc_opcode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      b_mem = b_mem_tbl[i];
      #1;
      check($sformatf("b_override_%0d", i), b_iord_override, 32'(i < 5));
      check($sformatf("b_iord_exc_%0d", i), b_iord_exc, (i < 5) ? 32'd1 : 32'd0);
      check($sformatf("b_busy_%0d", i), b_exc_busy, 32'(i < 5));
      check($sformatf("b_epc_write_%0d", i), b_epc_write, 32'(i == 0));
      check($sformatf("b_pc_write_%0d", i), b_pc_write, 32'(i == 4));
      check($sformatf("b_done_%0d", i), b_exc_done, 32'(i == 4));
      check($sformatf("b_pc_out_%0d", i), b_pc_out, (i == 4) ? 32'h7C : 32'h0);
    end
    check("b_epc_out", b_epc_out, 32'h0000_1004);
    check("b_cause", b_cause, 2'b01);

    repeat (3) @(posedge clk);
    #1 check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
